// File: rtl/sound_pkg.sv
// Shared types for the note sequencer: queued note record, playback FSM states,
// and the production millisecond prescale.
package sound_pkg;

  typedef struct packed {
    logic [31:0] period;
    logic [15:0] duration;
  } note_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int DEFAULT_TICKS_PER_MS = 100000;

endpackage

// File: rtl/sound_fifo.sv
// First-word-fall-through note queue; dout always shows the head entry.
// Full/empty reflect the start-of-cycle occupancy, so a same-cycle pop never makes room.
module sound_fifo
  import sound_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock100,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  note_t                    din,
  output note_t                    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  note_t             mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign level     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full && !clear;
  assign pop_ok_s  = pop && !empty && !clear;

  // Storage array; written only on an accepted push.
  always_ff @(posedge clock100) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy counter; clear empties the queue.
  always_ff @(posedge clock100 or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Plays queued (period, duration) notes back-to-back into the tone generator,
// holding each note for its programmed number of milliseconds.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int TICKS_PER_MS = DEFAULT_TICKS_PER_MS
) (
  input  logic                     clock100,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [31:0]              wr_period,
  input  logic [15:0]              wr_duration,
  input  logic                     flush,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic [31:0]              period,
  output logic                     aud_en
);

  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MS - 1);

  state_t        state_r, state_s;
  logic [TW-1:0] tick_r, tick_s;
  logic [15:0]   ms_left_r, ms_left_s;
  logic [31:0]   period_r, period_s;
  logic          busy_r, busy_s;
  logic          aud_en_r, aud_en_s;
  logic          pop_s;
  logic          empty_s;
  logic          head_ok_s;
  note_t         head_s;
  note_t         din_s;

  assign din_s.period   = wr_period;
  assign din_s.duration = wr_duration;
  assign head_ok_s      = !empty_s && (head_s.duration != 16'd0);

  sound_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock100 (clock100),
    .reset    (reset),
    .push     (wr_en && !flush),
    .pop      (pop_s),
    .clear    (flush),
    .din      (din_s),
    .dout     (head_s),
    .full     (full),
    .empty    (empty_s),
    .level    (level)
  );

  // Next-state logic: note loading, ms prescaler and note-end chaining.
  always_comb begin
    state_s   = state_r;
    tick_s    = tick_r;
    ms_left_s = ms_left_r;
    period_s  = period_r;
    pop_s     = 1'b0;
    if (flush) begin
      state_s   = IDLE;
      tick_s    = '0;
      ms_left_s = 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            pop_s = 1'b1;
            if (head_ok_s) begin
              period_s  = head_s.period;
              ms_left_s = head_s.duration;
              tick_s    = '0;
              state_s   = PLAY;
            end else begin
              state_s = IDLE;
            end
          end else begin
            state_s = IDLE;
          end
        end
        PLAY: begin
          if (tick_r == TICK_LAST) begin
            tick_s = '0;
            if (ms_left_r == 16'd1) begin
              // Chain straight into the next note so there is no gap cycle.
              if (head_ok_s) begin
                pop_s     = 1'b1;
                period_s  = head_s.period;
                ms_left_s = head_s.duration;
              end else begin
                state_s = IDLE;
              end
            end else begin
              ms_left_s = ms_left_r - 16'd1;
            end
          end else begin
            tick_s = tick_r + TW'(1);
          end
        end
        default: begin
          state_s   = IDLE;
          tick_s    = '0;
          ms_left_s = 16'd0;
        end
      endcase
    end
    busy_s   = (state_s == PLAY);
    aud_en_s = (state_s == PLAY) && (period_s != 32'd0);
  end

  // State and output registers.
  always_ff @(posedge clock100 or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      tick_r    <= '0;
      ms_left_r <= 16'd0;
      period_r  <= 32'd0;
      busy_r    <= 1'b0;
      aud_en_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      tick_r    <= tick_s;
      ms_left_r <= ms_left_s;
      period_r  <= period_s;
      busy_r    <= busy_s;
      aud_en_r  <= aud_en_s;
    end
  end

  assign busy   = busy_r;
  assign period = period_r;
  assign aud_en = aud_en_r;

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Note sequencer that sits directly upstream of the square-wave tone generator. It buffers (period, duration) note commands written by the CPU's memory-mapped sound register, then plays them back-to-back. It drives the generator's 32-bit period input and the audio enable, holding each note for its programmed number of milliseconds. With it, software can queue a short melody and continue executing instead of busy-waiting per note.

## Interface
Parameters:
- DEPTH, 8: note FIFO entries; power of two, at least 2.
- TICKS_PER_MS, 100000: clock100 cycles per millisecond; benches override to 4.

Ports:
- clock100  in  1  100 MHz system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears FIFO and playback immediately.
- wr_en  in  1  push one note this cycle.
- wr_period  in  32  tone period in 10 ns units; 0 means rest (silence).
- wr_duration  in  16  note length in ms; 0 means discard entry.
- flush  in  1  synchronous stop: empty FIFO, abort current note.
- full  out  1  FIFO holds DEPTH entries.
- level  out  $clog2(DEPTH)+1  entries queued, excluding the note playing.
- busy  out  1  a note (or rest) is currently playing.
- period  out  32  period to tone generator; held for the whole note.
- aud_en  out  1  audio enable to the output amplifier.

## Operation
- FIFO of note_t {period[31:0], duration[15:0]}.
  - Push when wr_en && !full.
  - Push while full is dropped silently; level unchanged.
  - Full is evaluated at the start of the cycle; a same-cycle pop does not make room.
- FSM, two states:
  - IDLE:
    - busy=0, aud_en=0; period holds its last value.
    - If FIFO is non-empty at an edge: pop head.
    - duration==0: discard the entry, stay IDLE, consider the next entry next cycle.
    - Otherwise load period, ms_left=duration, tick=0, and go to PLAY.
  - PLAY:
    - busy=1; aud_en = (period != 0).
    - tick counts 0..TICKS_PER_MS-1 and wraps.
    - On each wrap, ms_left decrements.
    - At the wrap where ms_left==1, the note ends.
    - Note end with FIFO non-empty and head duration != 0: pop and load it in the same edge; stay PLAY with no gap cycle.
    - Note end otherwise: go to IDLE. A zero-duration head is then discarded from IDLE.
- Simultaneous push and pop: both occur; level unchanged.
- A push into an empty FIFO is not visible to the pop logic until the next edge.
- flush:
  - Highest priority after reset.
  - At the edge: FIFO emptied, state goes to IDLE, aud_en drops, tick and ms_left cleared.
  - A wr_en in the same cycle is ignored.
- Arithmetic:
  - tick is $clog2(TICKS_PER_MS) bits.
  - ms_left is 16 bits, unsigned; it never underflows because 0 is never loaded.
  - FIFO pointers are $clog2(DEPTH) bits with natural wrap; level is the occupancy counter.

## Timing
- Reset values:
  - full=0, level=0, busy=0, aud_en=0, period=0.
  - FSM=IDLE, FIFO pointers 0.
  - Reset is asynchronous, so outputs clear without a clock edge.
- Start latency:
  - Push at edge N into an empty, idle sequencer.
  - Pop/load at edge N+1; busy, aud_en and period are valid after edge N+1.
- Note length: a note of D ms holds busy=1 for exactly D*TICKS_PER_MS cycles.
- Back-to-back notes: period changes at exactly the end edge of the previous note; busy stays 1.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset or flush mid-note: silence within the same cycle (reset) or after the next edge (flush).

## Structure
- Package sound_pkg holds:
  - note_t struct;
  - state_t enum {IDLE, PLAY};
  - DEFAULT_TICKS_PER_MS = 100000.
- Sub-module sound_fifo:
  - parameterised DEPTH;
  - ports: push, pop, clear, din, dout, full, empty, level;
  - first-word-fall-through so dout shows the head.
- Top-level sound_sequencer: FSM, tick prescaler, ms_left counter, output registers.

## Test plan
All scenarios use TICKS_PER_MS=4.
- Reset mid-note: push {1000,3} and wait 5 cycles; assert reset -> aud_en, busy, period, level all 0 immediately, and stay 0 after release.
- Single note: push {100000,2} at cycle 0 -> period=100000 and aud_en=1 from cycle 1 through cycle 8; busy=0 and aud_en=0 at cycle 9.
- Back-to-back: push {50,1}, {0,1}, {70,2} in consecutive cycles:
  - period=50 for 4 cycles with aud_en=1;
  - then period=0 for 4 cycles with aud_en=0 and busy=1;
  - then period=70 for 8 cycles;
  - no idle cycle between notes.
- Overflow: while idle-blocked by a long note, push DEPTH+2 entries -> level saturates at DEPTH, full=1; the last 2 entries are never played.
- Zero duration and flush:
  - Push {10,0} then {20,1} -> the 10 entry never appears on period; 20 plays for 4 cycles.
  - Then flush mid-note with wr_en=1 -> level=0, aud_en=0 next edge; the written entry is absent.
